// File: rtl/ones_count_dp.sv
// Datapath for a shift-and-count ones counter driven by an external one-hot controller.
// Optional define ONES_COUNT_ZERO_GUARD_EN lets a zero operand finish instead of stalling in T1.
module ones_count_dp (
  input  logic       clk,
  input  logic       rst,
  input  logic       t0,
  input  logic       t1,
  input  logic       t2,
  input  logic [7:0] data_in,
  output logic       x,
  output logic       z,
  output logic [3:0] result,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    CTL_T0,
    CTL_T1,
    CTL_T2,
    CTL_ILLEGAL
  } ctl_e;

  ctl_e       ctl;
  logic [7:0] r1_q, r1_d;
  logic [3:0] r2_q, r2_d;
  logic [3:0] result_q, result_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       tail_zero;
  logic       x_raw, z_raw;

  always_comb begin
    case ({t0, t1, t2})
      3'b100:  ctl = CTL_T0;
      3'b010:  ctl = CTL_T1;
      3'b001:  ctl = CTL_T2;
      default: ctl = CTL_ILLEGAL;
    endcase
  end

  assign tail_zero = (r1_q[6:0] == '0);

  always_comb begin
    r1_d     = r1_q;
    r2_d     = r2_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    x_raw    = 1'b0;
    z_raw    = 1'b0;
    case (ctl)
      CTL_T0: begin
        r1_d = data_in;
        r2_d = '0;
      end
      CTL_T1: begin
        x_raw = r1_q[7];
        if (!r1_q[7]) r1_d = {r1_q[6:0], 1'b0};
`ifdef ONES_COUNT_ZERO_GUARD_EN
        if (r1_q == '0) begin
          x_raw = 1'b1;
          r1_d  = r1_q;
        end
`endif
      end
      CTL_T2: begin
        x_raw = r1_q[6];
        z_raw = tail_zero;
        r1_d  = {r1_q[6:0], 1'b0};
        if (r1_q[7]) r2_d = r2_q + 4'd1;
        // The bit leaving R1[7] on this edge still has to be counted.
        if (tail_zero) begin
          result_d = r2_q + {3'b000, r1_q[7]};
          done_d   = 1'b1;
        end
      end
      default: err_d = 1'b1;
    endcase
  end

  // Status lines are quiet while reset is held so every output reads 0.
  assign x      = x_raw & rst;
  assign z      = z_raw & rst;
  assign result = result_q;
  assign done   = done_q;
  assign err    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_q     <= '0;
      r2_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ones_count_dp.sv
// Self-checking bench for ones_count_dp: a behavioural controller drives t0/t1/t2 and a
// bit-level reference model predicts counts, phase lengths and the completion pulse.
module tb_ones_count_dp;

  logic       clk = 1'b0;
  logic       rst;
  logic       t0, t1, t2;
  logic [7:0] data_in;
  logic       x, z;
  logic [3:0] result;
  logic       done, err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  last_result = '0;

  ones_count_dp dut (
    .clk(clk), .rst(rst), .t0(t0), .t1(t1), .t2(t2), .data_in(data_in),
    .x(x), .z(z), .result(result), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: popcount plus expected T1/T2 cycle counts for a controller that
  // stays in T1 until x, then in T2 until z.
  task automatic model(input logic [7:0] val, output int n1, output int n2, output int pop);
    int msb, lsb;
    msb = -1; lsb = -1; pop = 0;
    for (int i = 0; i < 8; i++) begin
      if (val[i]) begin
        pop++;
        if (lsb < 0) lsb = i;
        msb = i;
      end
    end
    if (val == 8'h00) begin n1 = 1; n2 = 1; end
    else begin n1 = 8 - msb; n2 = msb - lsb + 1; end
  endtask

  task automatic run_op(input logic [7:0] val, input bit do_load,
                        output int n1, output int n2, output bit timeout, output bit early,
                        output logic [3:0] res, output logic done_end, output logic done_after);
    int st;
    n1 = 0; n2 = 0; timeout = 1'b1; early = 1'b0; st = 1;
    if (do_load) begin
      @(negedge clk); t0 = 1; t1 = 0; t2 = 0; data_in = val;
      @(posedge clk);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      t0 = 0; t1 = (st == 1); t2 = (st == 2); data_in = 8'($urandom);
      #1;
      if (done !== 1'b0 || result !== last_result) early = 1'b1;
      if (st == 1) begin n1++; if (x) st = 2; end
      else begin n2++; if (z) st = 0; end
      @(posedge clk);
      if (st == 0) begin timeout = 1'b0; break; end
    end
    #1;
    res = result; done_end = done;
    @(negedge clk); t0 = 1; t1 = 0; t2 = 0;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset;
    rst = 0; t0 = 0; t1 = 0; t2 = 0; data_in = '0;
    #3;
    checks++;
    if ({result, done, err, x, z} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %h expected 00", {result, done, err, x, z});
    end
    @(negedge clk); t0 = 1;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    checks++;
    if (result !== 4'd0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_release: result=%0d done=%b err=%b expected 0 0 0", result, done, err);
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] val, input bit do_load, input bit chk_phases);
    int n1, n2, e1, e2, pop;
    bit timeout, early;
    logic [3:0] res;
    logic de, da;
    model(val, e1, e2, pop);
    run_op(val, do_load, n1, n2, timeout, early, res, de, da);
    checks++;
    if (timeout) begin errors++; $display("FAIL %s_timeout: operand %h never completed", name, val); end
    checks++;
    if (res !== 4'(pop)) begin errors++; $display("FAIL %s_result: got %0d expected %0d (operand %h)", name, res, pop, val); end
    checks++;
    if (de !== 1'b1 || da !== 1'b0) begin
      errors++; $display("FAIL %s_done_pulse: got %b%b expected 10 (operand %h)", name, de, da, val);
    end
    checks++;
    if (early) begin errors++; $display("FAIL %s_during_op: done or result changed early (operand %h)", name, val); end
    if (chk_phases) begin
      checks++;
      if (n1 != e1 || n2 != e2) begin
        errors++; $display("FAIL %s_phases: got T1=%0d T2=%0d expected T1=%0d T2=%0d", name, n1, n2, e1, e2);
      end
    end
    checks++;
    if (n1 + n2 > 9) begin errors++; $display("FAIL %s_latency: got %0d cycles expected <=9", name, n1 + n2); end
    last_result = 4'(pop);
  endtask

  task automatic test_directed;
    logic [7:0] vals [3];
    vals[0] = 8'hB4; vals[1] = 8'hFF; vals[2] = 8'h01;
    foreach (vals[i]) check_op("directed", vals[i], 1'b1, 1'b1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL directed_err: got %b expected 0", err); end
  endtask

  task automatic test_zero;
`ifdef ONES_COUNT_ZERO_GUARD_EN
    check_op("zero_guard", 8'h00, 1'b1, 1'b1);
`else
    int bad;
    bad = 0;
    @(negedge clk); t0 = 1; t1 = 0; t2 = 0; data_in = 8'h00;
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); t0 = 0; t1 = 1; data_in = 8'($urandom);
      #1;
      checks++;
      if (x !== 1'b0 || done !== 1'b0) begin
        errors++; bad++; $display("FAIL zero_stall: cycle %0d got x=%b done=%b expected 0 0", c, x, done);
      end
    end
    @(negedge clk); t0 = 1; t1 = 0;
    @(posedge clk);
`endif
  endtask

  task automatic test_random;
    logic [7:0] v;
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom_range(1, 255));
      check_op("random", v, 1'b1, 1'b1);
    end
  endtask

  task automatic test_illegal;
    @(negedge clk); t0 = 1; t1 = 0; t2 = 0; data_in = 8'hB4;
    @(posedge clk);
    @(negedge clk); t0 = 1; t1 = 1; t2 = 0; data_in = 8'h00;
    #1;
    checks++;
    if (x !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL illegal_status: got x=%b z=%b expected 0 0", x, z); end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", err); end
    checks++;
    if (result !== last_result || done !== 1'b0) begin
      errors++; $display("FAIL illegal_hold: result=%0d done=%b expected %0d 0", result, done, last_result);
    end
    @(negedge clk); t0 = 0; t1 = 0; t2 = 0;
    @(posedge clk);
    // Resuming without a reload shows R1/R2 survived the illegal cycles.
    check_op("illegal_resume", 8'hB4, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b expected 1", err); end
    @(negedge clk); rst = 0;
    #1;
    checks++;
    if (err !== 1'b0 || result !== 4'd0) begin
      errors++; $display("FAIL illegal_clear: err=%b result=%0d expected 0 0", err, result);
    end
    @(negedge clk); rst = 1;
    last_result = '0;
  endtask

  task automatic test_reset_mid_op;
    check_op("pre_abort", 8'hB4, 1'b1, 1'b0);
    @(negedge clk); t0 = 1; t1 = 0; t2 = 0; data_in = 8'hB4;
    @(negedge clk); t0 = 0; t1 = 1;
    @(negedge clk); t1 = 0; t2 = 1;
    @(negedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if ({result, done, err, x, z} !== 8'h00) begin
      errors++; $display("FAIL abort_outputs: got %h expected 00", {result, done, err, x, z});
    end
    @(negedge clk); t0 = 1; t2 = 0;
    @(negedge clk); rst = 1;
    last_result = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result !== 4'd0) begin
        errors++; $display("FAIL abort_no_done: cycle %0d done=%b result=%0d expected 0 0", c, done, result);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_zero;
    test_random;
    test_illegal;
    test_reset_mid_op;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
